// File: rtl/ycbcr_pkg.sv
// Shared constants for the BT.601 full-range colour-space converters (forward and inverse).
package ycbcr_pkg;

    localparam int unsigned FRAC_BITS_DEF = 10;
    localparam int unsigned CHROMA_OFFSET = 128;
    localparam int unsigned PIPE_LAT      = 4;

    // Coefficients in parts per million, scaled to fixed point by coef().
    localparam int unsigned RCR_PPM = 1402000;
    localparam int unsigned GCB_PPM = 344136;
    localparam int unsigned GCR_PPM = 714136;
    localparam int unsigned BCB_PPM = 1772000;

    localparam int unsigned YR_PPM  = 299000;
    localparam int unsigned YG_PPM  = 587000;
    localparam int unsigned YB_PPM  = 114000;
    localparam int unsigned CBR_PPM = 168736;
    localparam int unsigned CBG_PPM = 331264;
    localparam int unsigned CRG_PPM = 418688;
    localparam int unsigned CRB_PPM = 81312;
    localparam int unsigned HALF_PPM = 500000;

    // Round-to-nearest fixed-point coefficient: round(ppm * 2^k / 1e6).
    function automatic int unsigned coef(input int unsigned ppm, input int unsigned k);
        longint unsigned t;
        t = (longint'(ppm) << k) + 64'd500000;
        return int'(t / 64'd1000000);
    endfunction

    // Inverse (ycbcr -> rgb) coefficients at the default precision.
    localparam int unsigned C_RCR = coef(RCR_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_GCB = coef(GCB_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_GCR = coef(GCR_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_BCB = coef(BCB_PPM, FRAC_BITS_DEF);

    // Forward (rgb -> ycbcr) coefficients at the default precision.
    localparam int unsigned C_YR  = coef(YR_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_YG  = coef(YG_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_YB  = coef(YB_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_CBR = coef(CBR_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_CBG = coef(CBG_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_CRG = coef(CRG_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_CRB = coef(CRB_PPM, FRAC_BITS_DEF);
    localparam int unsigned C_HALF = coef(HALF_PPM, FRAC_BITS_DEF);

endpackage

// File: rtl/ycbcr_to_rgb_if.sv
// Pixel and VGA-style control bundle into and out of the YCbCr -> RGB decoder.
interface ycbcr_to_rgb_if;

    logic [7:0] i_y_8b;
    logic [7:0] i_cb_8b;
    logic [7:0] i_cr_8b;
    logic       i_h_sync;
    logic       i_v_sync;
    logic       i_data_en;
    logic [7:0] o_r_8b;
    logic [7:0] o_g_8b;
    logic [7:0] o_b_8b;
    logic       o_h_sync;
    logic       o_v_sync;
    logic       o_data_en;

    // Upstream video source.
    modport master (
        output i_y_8b, i_cb_8b, i_cr_8b, i_h_sync, i_v_sync, i_data_en,
        input  o_r_8b, o_g_8b, o_b_8b, o_h_sync, o_v_sync, o_data_en
    );

    // The decoder itself.
    modport slave (
        input  i_y_8b, i_cb_8b, i_cr_8b, i_h_sync, i_v_sync, i_data_en,
        output o_r_8b, o_g_8b, o_b_8b, o_h_sync, o_v_sync, o_data_en
    );

endinterface

// File: rtl/sync_delay.sv
// Async-reset shift register; tap_o is one stage short of data_o so the consumer
// can act on a control bit in the same cycle it registers its own output.
module sync_delay #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             pixel_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] tap_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift one stage per clock; stage 0 holds the newest sample.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[DEPTH-2:0], data_i};
        end
    end

    assign data_o = stage_q[DEPTH-1];
    assign tap_o  = stage_q[DEPTH-2];

endmodule

// File: rtl/ycbcr_to_rgb.sv
// BT.601 full-range YCbCr 4:4:4 -> RGB, four-stage fixed-latency pipeline with
// sync/data_en carried alongside the pixel data.
module ycbcr_to_rgb
    import ycbcr_pkg::*;
#(
    parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
    parameter bit          BLANK_ZERO = 1'b1
) (
    input logic            pixel_clk,
    input logic            reset_n,
    ycbcr_to_rgb_if.slave  bus
);

    // 8 integer bits + sign + headroom: worst-case |sum| stays below 2^(FRAC_BITS+9).
    localparam int unsigned W = FRAC_BITS + 11;

    localparam logic signed [W-1:0] K_RCR = W'(coef(RCR_PPM, FRAC_BITS));
    localparam logic signed [W-1:0] K_GCB = W'(coef(GCB_PPM, FRAC_BITS));
    localparam logic signed [W-1:0] K_GCR = W'(coef(GCR_PPM, FRAC_BITS));
    localparam logic signed [W-1:0] K_BCB = W'(coef(BCB_PPM, FRAC_BITS));
    localparam logic signed [W-1:0] RND   = W'(64'd1 << (FRAC_BITS - 1));
    localparam logic signed [8:0]   OFF9  = 9'(CHROMA_OFFSET);
    localparam logic signed [W-1:0] MAX8  = W'(255);

    // S1
    logic signed [W-1:0] yk1_q, yk1_d;
    logic signed [8:0]   dcb1_q, dcb1_d, dcr1_q, dcr1_d;
    // S2
    logic signed [W-1:0] yk2_q, yk2_d;
    logic signed [W-1:0] p_rcr_q, p_rcr_d, p_gcb_q, p_gcb_d, p_gcr_q, p_gcr_d, p_bcb_q, p_bcb_d;
    // S3
    logic signed [W-1:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    // S4
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

    logic signed [W-1:0] dcb_w, dcr_w;
    logic [2:0] ctrl_out, ctrl_tap;

    // Saturate a signed integer to the 0..255 pixel range.
    function automatic logic [7:0] clamp8(input logic signed [W-1:0] v);
        if (v[W-1]) begin
            return 8'd0;
        end else if (v > MAX8) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

    // Control bits {h_sync, v_sync, data_en} travel in lock-step with the data.
    sync_delay #(
        .DEPTH (PIPE_LAT),
        .WIDTH (3)
    ) u_sync_delay (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .data_i    ({bus.i_h_sync, bus.i_v_sync, bus.i_data_en}),
        .data_o    (ctrl_out),
        .tap_o     (ctrl_tap)
    );

    // Next-state for every pipeline stage.
    always_comb begin
        yk1_d  = W'({bus.i_y_8b, {FRAC_BITS{1'b0}}});
        dcb1_d = $signed({1'b0, bus.i_cb_8b}) - OFF9;
        dcr1_d = $signed({1'b0, bus.i_cr_8b}) - OFF9;

        dcb_w   = $signed({{(W-9){dcb1_q[8]}}, dcb1_q});
        dcr_w   = $signed({{(W-9){dcr1_q[8]}}, dcr1_q});
        yk2_d   = yk1_q;
        p_rcr_d = dcr_w * K_RCR;
        p_gcb_d = dcb_w * K_GCB;
        p_gcr_d = dcr_w * K_GCR;
        p_bcb_d = dcb_w * K_BCB;

        sum_r_d = yk2_q + p_rcr_q + RND;
        sum_g_d = yk2_q - p_gcb_q - p_gcr_q + RND;
        sum_b_d = yk2_q + p_bcb_q + RND;

        r_d = clamp8(sum_r_q >>> FRAC_BITS);
        g_d = clamp8(sum_g_q >>> FRAC_BITS);
        b_d = clamp8(sum_b_q >>> FRAC_BITS);
        // ctrl_tap[0] is the data_en that will leave alongside this pixel.
        if (BLANK_ZERO && !ctrl_tap[0]) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    // Pipeline registers, cleared asynchronously.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            yk1_q   <= '0;
            dcb1_q  <= '0;
            dcr1_q  <= '0;
            yk2_q   <= '0;
            p_rcr_q <= '0;
            p_gcb_q <= '0;
            p_gcr_q <= '0;
            p_bcb_q <= '0;
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            yk1_q   <= yk1_d;
            dcb1_q  <= dcb1_d;
            dcr1_q  <= dcr1_d;
            yk2_q   <= yk2_d;
            p_rcr_q <= p_rcr_d;
            p_gcb_q <= p_gcb_d;
            p_gcr_q <= p_gcr_d;
            p_bcb_q <= p_bcb_d;
            sum_r_q <= sum_r_d;
            sum_g_q <= sum_g_d;
            sum_b_q <= sum_b_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign bus.o_r_8b    = r_q;
    assign bus.o_g_8b    = g_q;
    assign bus.o_b_8b    = b_q;
    assign bus.o_h_sync  = ctrl_out[2];
    assign bus.o_v_sync  = ctrl_out[1];
    assign bus.o_data_en = ctrl_out[0];

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Scoreboard bench for ycbcr_to_rgb: stimulus pushes expected outputs, a monitor pops them.
module tb_ycbcr_to_rgb;

    typedef struct {
        logic [7:0] r, g, b;
        logic       hs, vs, de;
        bit         rt;
        logic [7:0] r0, g0, b0;
    } exp_t;

    logic pixel_clk = 1'b0;
    logic reset_n;
    ycbcr_to_rgb_if vif ();

    ycbcr_to_rgb #(
        .FRAC_BITS  (10),
        .BLANK_ZERO (1'b1)
    ) dut (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .bus       (vif)
    );

    always #5 pixel_clk = ~pixel_clk;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   rt_count = 0;
    bit   mon_en   = 1'b0;

    int dir_in [7][3] = '{'{128, 128, 128}, '{255, 128, 128}, '{0, 128, 128}, '{76, 85, 255},
                          '{255, 128, 255}, '{0, 128, 0}, '{0, 0, 128}};
    int dir_exp[7][3] = '{'{128, 128, 128}, '{255, 255, 255}, '{0, 0, 0}, '{254, 0, 0},
                          '{255, 164, 255}, '{0, 91, 0}, '{0, 44, 0}};

    function automatic logic [7:0] sat8(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: R = Y + 1.402 dCr etc., coefficients scaled by 1024, round half up, clamp.
    task automatic model(input int y, cb, cr, input logic hs, vs, de, output exp_t e,
                         output int peak);
        int rr, gg, bb;
        rr = y * 1024 + 1436 * (cr - 128) + 512;
        gg = y * 1024 - 352 * (cb - 128) - 731 * (cr - 128) + 512;
        bb = y * 1024 + 1815 * (cb - 128) + 512;
        peak = iabs(rr);
        if (iabs(gg) > peak) peak = iabs(gg);
        if (iabs(bb) > peak) peak = iabs(bb);
        e = '{default: '0};
        e.hs = hs;
        e.vs = vs;
        e.de = de;
        if (de) begin
            e.r = sat8(rr >>> 10);
            e.g = sat8(gg >>> 10);
            e.b = sat8(bb >>> 10);
        end
    endtask

    // Forward BT.601 full-range conversion in floating point.
    function automatic logic [7:0] rnd8(input real x);
        if (x < 0.0) return 8'd0;
        return sat8($rtoi(x + 0.5));
    endfunction

    // Assumes the caller sits on a negedge; applies the pixel and returns on the next negedge.
    task automatic drive_exp(input logic [7:0] y, cb, cr, input logic hs, vs, de, input exp_t e);
        vif.i_y_8b    = y;
        vif.i_cb_8b   = cb;
        vif.i_cr_8b   = cr;
        vif.i_h_sync  = hs;
        vif.i_v_sync  = vs;
        vif.i_data_en = de;
        q.push_back(e);
        @(negedge pixel_clk);
    endtask

    task automatic drive(input logic [7:0] y, cb, cr, input logic hs, vs, de);
        exp_t e;
        int   peak;
        model(int'(y), int'(cb), int'(cr), hs, vs, de, e, peak);
        n_checks++;
        if (peak >= (1 << 19)) begin
            n_errors++;
            $display("FAIL range: |intermediate|=%0d required < %0d", peak, 1 << 19);
        end
        drive_exp(y, cb, cr, hs, vs, de, e);
    endtask

    task automatic push_idle();
        exp_t z;
        z = '{default: '0};
        repeat (3) q.push_back(z);
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({vif.o_r_8b, vif.o_g_8b, vif.o_b_8b, vif.o_h_sync, vif.o_v_sync, vif.o_data_en} != '0) begin
            n_errors++;
            $display("FAIL %s: got rgb=%0d,%0d,%0d hs=%b vs=%b de=%b required all 0", name,
                     vif.o_r_8b, vif.o_g_8b, vif.o_b_8b, vif.o_h_sync, vif.o_v_sync, vif.o_data_en);
        end
    endtask

    // Monitor: one output per clock, compared against the head of the scoreboard.
    always begin
        exp_t e;
        int   d;
        @(posedge pixel_clk);
        #2;
        if (mon_en) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard: got output with empty queue, required queued entry");
            end else begin
                e = q.pop_front();
                if (vif.o_r_8b !== e.r || vif.o_g_8b !== e.g || vif.o_b_8b !== e.b ||
                    vif.o_h_sync !== e.hs || vif.o_v_sync !== e.vs || vif.o_data_en !== e.de) begin
                    n_errors++;
                    $display("FAIL pixel @%0t: got rgb=%0d,%0d,%0d hs=%b vs=%b de=%b required rgb=%0d,%0d,%0d hs=%b vs=%b de=%b",
                             $time, vif.o_r_8b, vif.o_g_8b, vif.o_b_8b, vif.o_h_sync, vif.o_v_sync,
                             vif.o_data_en, e.r, e.g, e.b, e.hs, e.vs, e.de);
                end
                if (e.rt) begin
                    rt_count++;
                    d = iabs(int'(vif.o_r_8b) - int'(e.r0));
                    if (iabs(int'(vif.o_g_8b) - int'(e.g0)) > d) d = iabs(int'(vif.o_g_8b) - int'(e.g0));
                    if (iabs(int'(vif.o_b_8b) - int'(e.b0)) > d) d = iabs(int'(vif.o_b_8b) - int'(e.b0));
                    n_checks++;
                    if (d > 2) begin
                        n_errors++;
                        $display("FAIL round_trip: got rgb=%0d,%0d,%0d required within 2 of %0d,%0d,%0d",
                                 vif.o_r_8b, vif.o_g_8b, vif.o_b_8b, e.r0, e.g0, e.b0);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   peak;
        logic [7:0] r0, g0, b0, y, cb, cr;
        logic hs, vs, act;

        // Reset with busy inputs: outputs must stay 0.
        reset_n = 1'b0;
        vif.i_y_8b = 8'd255; vif.i_cb_8b = 8'd200; vif.i_cr_8b = 8'd200;
        vif.i_h_sync = 1'b1; vif.i_v_sync = 1'b1; vif.i_data_en = 1'b1;
        repeat (2) @(posedge pixel_clk);
        #2;
        check_all_zero("reset");
        @(negedge pixel_clk);
        reset_n = 1'b1;
        push_idle();
        mon_en = 1'b1;

        // Directed vectors with hand-derived results.
        for (int i = 0; i < 7; i++) begin
            e = '{default: '0};
            e.r = 8'(dir_exp[i][0]); e.g = 8'(dir_exp[i][1]); e.b = 8'(dir_exp[i][2]);
            e.hs = i[0]; e.vs = i[1]; e.de = 1'b1;
            drive_exp(8'(dir_in[i][0]), 8'(dir_in[i][1]), 8'(dir_in[i][2]), i[0], i[1], 1'b1, e);
        end

        // Random pixels and control.
        for (int i = 0; i < 200; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom));
        end

        // data_en toggling every cycle.
        for (int i = 0; i < 40; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, i[0]);
        end

        // Reduced frame: 24x6 active in 32x10 total, round-tripped from random RGB.
        for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < 32; h++) begin
                act = (h < 24) && (v < 6);
                hs  = (h >= 26) && (h < 30);
                vs  = (v >= 7) && (v < 9);
                if (act) begin
                    r0 = 8'($urandom); g0 = 8'($urandom); b0 = 8'($urandom);
                    y  = rnd8(0.299 * r0 + 0.587 * g0 + 0.114 * b0);
                    cb = rnd8(128.0 - 0.168736 * r0 - 0.331264 * g0 + 0.5 * b0);
                    cr = rnd8(128.0 + 0.5 * r0 - 0.418688 * g0 - 0.081312 * b0);
                    model(int'(y), int'(cb), int'(cr), hs, vs, 1'b1, e, peak);
                    e.rt = 1'b1; e.r0 = r0; e.g0 = g0; e.b0 = b0;
                    drive_exp(y, cb, cr, hs, vs, 1'b1, e);
                end else begin
                    drive(8'($urandom), 8'($urandom), 8'($urandom), hs, vs, 1'b0);
                end
            end
        end

        // Reset mid-line during active white video.
        repeat (6) drive(8'd255, 8'd128, 8'd128, 1'b1, 1'b0, 1'b1);
        @(posedge pixel_clk);
        #3;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_line");
        repeat (2) @(negedge pixel_clk);
        reset_n = 1'b1;
        q.delete();
        push_idle();
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end

        // Drain: the last three idle pixels stay queued behind the final compare.
        repeat (3) drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b0;
        n_checks++;
        if (q.size() != 3) begin
            n_errors++;
            $display("FAIL drain: got %0d queued required 3", q.size());
        end
        n_checks++;
        if (rt_count != 144) begin
            n_errors++;
            $display("FAIL pixel_count: got %0d required 144", rt_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ycbcr_to_rgb.md
Name: ycbcr_to_rgb

Overview:
- Pipelined colour-space decoder: BT.601 full-range 8-bit YCbCr 4:4:4 in, 8-bit RGB out.
- It is the inverse of rgb_to_ycbcr and sits downstream of it in the video path, for example between the converter output and imwrite.
- It carries VGA-style h_sync/v_sync/data_en through with the same latency as the pixel data.
- It closes the round trip rgb -> ycbcr -> rgb for simulation and for display.

Parameters:
- FRAC_BITS, 10: fractional bits of the fixed-point coefficients. Coefficient constants are derived for this value.
- BLANK_ZERO, 1: when 1, RGB outputs are forced to 0 while the delayed data_en is low. When 0, the converted value passes through.

Ports:
- pixel_clk  in  1  pixel clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- i_y_8b  in  8  luma, unsigned 0..255.
- i_cb_8b  in  8  blue-difference chroma, offset-128 unsigned.
- i_cr_8b  in  8  red-difference chroma, offset-128 unsigned.
- i_h_sync  in  1  horizontal sync, passed through.
- i_v_sync  in  1  vertical sync, passed through.
- i_data_en  in  1  active-video qualifier.
- o_r_8b  out  8  red, clamped 0..255.
- o_g_8b  out  8  green, clamped 0..255.
- o_b_8b  out  8  blue, clamped 0..255.
- o_h_sync  out  1  i_h_sync delayed 4 cycles.
- o_v_sync  out  1  i_v_sync delayed 4 cycles.
- o_data_en  out  1  i_data_en delayed 4 cycles.

Behaviour:
- Clocking and reset:
  - One clock. reset_n is asynchronous, active-low.
  - While reset_n=0, every pipeline register and every output is 0: o_r/g/b=0, o_h_sync=0, o_v_sync=0, o_data_en=0.
- Equations, all integer, with K=FRAC_BITS:
  - R = Y + 1.402*(Cr-128)
  - G = Y - 0.344136*(Cb-128) - 0.714136*(Cr-128)
  - B = Y + 1.772*(Cb-128)
  - Coefficients for K=10: C_RCR=1436, C_GCB=352, C_GCR=731, C_BCB=1815.
- Pipeline, fixed latency 4 cycles, no stalls, one pixel per clock, no backpressure:
  - S1: register inputs. Form signed 9-bit dcb=Cb-128 and dcr=Cr-128. Form yk = Y<<K.
  - S2: register the four products C*d as signed 21-bit values, and forward yk.
  - S3: register the three sums plus rounding constant 2^(K-1), signed 21-bit.
  - S4: arithmetic shift right by K. Clamp: result <0 gives 0, result >255 gives 255, otherwise the low 8 bits. Register the outputs.
- Intermediate range:
  - Worst case |sum| < 2^19, so signed 21 bits has no overflow.
  - The bench checks that no intermediate saturates.
- Control path:
  - h_sync, v_sync and data_en each pass through a 4-deep shift register.
  - Output control bits are cycle-aligned with the RGB they qualify.
- Blanking:
  - If BLANK_ZERO=1 and S4 data_en=0, RGB registers load 0.
  - Syncs are never modified.
- Boundary conditions:
  - Back-to-back pixels: every cycle is independent; no state carries between pixels.
  - data_en toggling every cycle: the output toggles identically, 4 cycles later.
  - Reset mid-line: all stages clear immediately (asynchronous).
  - After reset release: the first 4 outputs are 0/idle, then valid results follow.
  - Clamping at either rail is silent; no error flag.

Decomposition:
- Shared package ycbcr_pkg holds:
  - FRAC_BITS default, coefficient constants C_RCR/C_GCB/C_GCR/C_BCB, CHROMA_OFFSET=128.
  - PIPE_LAT=4. rgb_to_ycbcr shares this package for its forward coefficients.
- One sub-module, sync_delay (parameter DEPTH, WIDTH): async-reset shift register used for {h_sync, v_sync, data_en}. The arithmetic stays in the top module.

Test Plan:
- Grey mid-scale: Y=128, Cb=128, Cr=128, de=1 -> R=G=B=128 exactly 4 cycles later. Then Y=255 / Y=0 with neutral chroma -> 255,255,255 and 0,0,0.
- Saturated red: Y=76, Cb=85, Cr=255 -> R=254, G=0, B=0 (B intermediate -221+512 >>10 = 0, no negative wrap).
- Clamp both rails:
  - Y=255, Cr=255, Cb=128 -> R=255.
  - Y=0, Cr=0, Cb=128 -> R=0, G=91.
  - Y=0, Cb=0 -> B=0.
- Timing alignment: drive an 800x600 frame with syncs from vga_ctl. o_h_sync, o_v_sync and o_data_en equal the inputs delayed 4 cycles on every cycle. With BLANK_ZERO=1, RGB=0 whenever o_data_en=0.
- Round trip: imread -> rgb_to_ycbcr -> ycbcr_to_rgb over a full frame. Every pixel satisfies |RGB_out - RGB_in| <= 2 per channel, and the pixel count equals 480000.
- Reset mid-line: assert reset_n=0 between clock edges during active video. All outputs are 0 immediately. After release, 4 idle cycles, then correct data for new inputs.
